// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the stall/flush
// sequencer (slave).
`timescale 1ns/1ps
interface pipeline_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [4:0]       ifid_rs_i;
   logic [4:0]       ifid_rt_i;
   logic             idex_memrd_i;
   logic [4:0]       idex_rt_i;
   logic             branch_taken_i;
   logic             exmem_mem_i;
   logic             dmem_ready_i;
   logic             pc_write_o;
   logic             ifid_hazard_o;
   logic             ifid_flush_o;
   logic             idex_bubble_o;
   logic             freeze_o;
   logic             mem_err_o;
   logic [CNT_W-1:0] stall_cnt_o;
   logic [CNT_W-1:0] flush_cnt_o;

   modport master (
      output ifid_rs_i, ifid_rt_i, idex_memrd_i, idex_rt_i,
             branch_taken_i, exmem_mem_i, dmem_ready_i,
      input  pc_write_o, ifid_hazard_o, ifid_flush_o, idex_bubble_o,
             freeze_o, mem_err_o, stall_cnt_o, flush_cnt_o
   );

   modport slave (
      input  ifid_rs_i, ifid_rt_i, idex_memrd_i, idex_rt_i,
             branch_taken_i, exmem_mem_i, dmem_ready_i,
      output pc_write_o, ifid_hazard_o, ifid_flush_o, idex_bubble_o,
             freeze_o, mem_err_o, stall_cnt_o, flush_cnt_o
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, taken-branch flushes,
// data-memory freeze with timeout, and saturating stall/flush event counters.
`timescale 1ns/1ps
module pipeline_hazard_ctrl #(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 64
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   pipeline_hazard_ctrl_if.slave hz
);

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              mem_err_q, mem_err_d;
   logic [CNT_W-1:0]  stall_q, flush_q;

   logic load_use;
   logic mem_hold;
   logic pc_write;
   logic ifid_hazard;
   logic ifid_flush;
   logic idex_bubble;
   logic freeze;

   // r0 is hardwired, so a load targeting it never creates a dependency.
   assign load_use = hz.idex_memrd_i && (hz.idex_rt_i != 5'd0) &&
                     ((hz.idex_rt_i == hz.ifid_rs_i) || (hz.idex_rt_i == hz.ifid_rt_i));
   assign mem_hold = hz.exmem_mem_i && !hz.dmem_ready_i;

   // NOTE: every signal written here gets a default first, so no path leaves one
   // unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      mem_err_d   = mem_err_q;
      pc_write    = 1'b1;
      ifid_hazard = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      freeze      = 1'b0;

      case (state_q)
         RUN:      if (mem_hold) state_d = MEM_WAIT;
         MEM_WAIT: if (!mem_hold) state_d = RUN;
         default:  state_d = RUN;
      endcase

      // Memory hold outranks load-use; a branch seen during a load-use stall
      // re-resolves next cycle, so it is simply dropped here.
      if (mem_hold) begin
         pc_write    = 1'b0;
         ifid_hazard = 1'b1;
         freeze      = 1'b1;
      end else if (load_use) begin
         pc_write    = 1'b0;
         ifid_hazard = 1'b1;
         idex_bubble = 1'b1;
      end else if (hz.branch_taken_i) begin
         ifid_flush  = 1'b1;
      end

      // Every frozen cycle counts toward the timeout; the freeze itself is never broken.
      if (state_d == RUN) begin
         wait_d = '0;
      end else if (wait_q != TIMEOUT_V) begin
         wait_d = wait_q + 1'b1;
      end
      if (wait_d == TIMEOUT_V) mem_err_d = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values regardless of process ordering.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q   <= RUN;
         wait_q    <= '0;
         mem_err_q <= 1'b0;
         stall_q   <= '0;
         flush_q   <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         mem_err_q <= mem_err_d;
         if (!pc_write && (stall_q != '1)) stall_q <= stall_q + 1'b1;
         if (ifid_flush && (flush_q != '1)) flush_q <= flush_q + 1'b1;
      end
   end

   assign hz.pc_write_o    = pc_write;
   assign hz.ifid_hazard_o = ifid_hazard;
   assign hz.ifid_flush_o  = ifid_flush;
   assign hz.idex_bubble_o = idex_bubble;
   assign hz.freeze_o      = freeze;
   assign hz.mem_err_o     = mem_err_q;
   assign hz.stall_cnt_o   = stall_q;
   assign hz.flush_cnt_o   = flush_q;

endmodule
